// File: rtl/load_store_unit.sv
// Registered memory-access stage: valid/ready request side, MEM_REQ/MEM_ACK bus side.
// Builds strobes and lane-replicated store data, extends load lanes, flags faults and bus timeouts.
module load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              CK_REF,
  input  logic              RST_N,
  input  logic              HALT,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  input  logic [4:0]        REQ_RD,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic [4:0]        RSP_RD,
  output logic [2:0]        RSP_ERR,
  output logic              STALL,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_WSTRB,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RDATA,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] ERR_OK      = 3'b000;
  localparam logic [2:0] ERR_MISALGN = 3'b001;
  localparam logic [2:0] ERR_RANGE   = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_ILLEGAL = 3'b100;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             l_write;
  logic [2:0]       l_funct3;
  logic [1:0]       l_lane;
  logic [4:0]       l_rd;

  logic             illegal;
  logic             misaligned;
  logic             out_of_range;
  logic [2:0]       req_err;
  logic [3:0]       req_strb;
  logic [31:0]      req_wdata;
  logic [31:0]      lane_data;
  logic [31:0]      load_data;
  logic             expire;

  // Handshake: a request transfers on a rising edge where REQ_VALID && REQ_READY; the
  // bus access completes on a rising edge where MEM_REQ && MEM_ACK; RSP_VALID is a
  // one-cycle pulse unless HALT holds it.
  assign REQ_READY = (state == IDLE) && !HALT;
  assign STALL     = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    illegal      = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3[2:1] == 2'b11) ||
                   (REQ_WRITE && REQ_FUNCT3[2]);
    misaligned   = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                   ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
    out_of_range = (REQ_ADDR >> ADDR_W) != 32'd0;
    if (illegal)           req_err = ERR_ILLEGAL;
    else if (misaligned)   req_err = ERR_MISALGN;
    else if (out_of_range) req_err = ERR_RANGE;
    else                   req_err = ERR_OK;
    case (REQ_FUNCT3[1:0])
      2'b00: begin
        req_strb  = 4'b0001 << REQ_ADDR[1:0];
        req_wdata = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        req_strb  = 4'b0011 << REQ_ADDR[1:0];
        req_wdata = {2{REQ_WDATA[15:0]}};
      end
      default: begin
        req_strb  = 4'b1111;
        req_wdata = REQ_WDATA;
      end
    endcase
  end

  // Load lane selection uses the offset latched at accept, not the live request port.
  always_comb begin
    lane_data = MEM_RDATA >> {l_lane, 3'b000};
    case (l_funct3)
      3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {24'd0, lane_data[7:0]};
      3'b101:  load_data = {16'd0, lane_data[15:0]};
      default: load_data = lane_data;
    endcase
  end

  assign expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      l_write   <= 1'b0;
      l_funct3  <= 3'd0;
      l_lane    <= 2'd0;
      l_rd      <= 5'd0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 32'd0;
      RSP_RD    <= 5'd0;
      RSP_ERR   <= 3'd0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WSTRB <= 4'd0;
      MEM_WDATA <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID && !HALT) begin
            l_write  <= REQ_WRITE;
            l_funct3 <= REQ_FUNCT3;
            l_lane   <= REQ_ADDR[1:0];
            l_rd     <= REQ_RD;
            if (req_err != ERR_OK) begin
              state     <= RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= req_err;
              RSP_RDATA <= 32'd0;
              RSP_RD    <= 5'd0;
            end else begin
              state     <= ACCESS;
              cnt       <= '0;
              MEM_REQ   <= 1'b1;
              MEM_WE    <= REQ_WRITE;
              MEM_ADDR  <= {REQ_ADDR[ADDR_W-1:2], 2'b00};
              MEM_WSTRB <= REQ_WRITE ? req_strb : 4'd0;
              MEM_WDATA <= REQ_WRITE ? req_wdata : 32'd0;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the expiry edge still completes the access.
          if (MEM_ACK) begin
            state     <= RESP;
            MEM_REQ   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= ERR_OK;
            RSP_RDATA <= l_write ? 32'd0 : load_data;
            RSP_RD    <= l_write ? 5'd0 : l_rd;
          end else if (!HALT) begin
            if (expire) begin
              state     <= RESP;
              MEM_REQ   <= 1'b0;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= ERR_TIMEOUT;
              RSP_RDATA <= 32'd0;
              RSP_RD    <= 5'd0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (!HALT) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'd0;
            RSP_RD    <= 5'd0;
            RSP_ERR   <= 3'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic, a bus responder and
// two scoreboards (bus fields, responses) fed from a behavioural reference model.
module tb_load_store_unit;

  localparam int ADDR_W = 16;
  localparam int TIMEOUT = 16;
  localparam int NEVER = 1000;
  localparam int BUS_W = ADDR_W + 37;

  logic              CK_REF = 1'b0;
  logic              RST_N = 1'b0;
  logic              HALT = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_WRITE = 1'b0;
  logic [2:0]        REQ_FUNCT3 = 3'd0;
  logic [31:0]       REQ_ADDR = 32'd0;
  logic [31:0]       REQ_WDATA = 32'd0;
  logic [4:0]        REQ_RD = 5'd0;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic [4:0]        RSP_RD;
  logic [2:0]        RSP_ERR;
  logic              STALL;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [3:0]        MEM_WSTRB;
  logic [31:0]       MEM_WDATA;
  logic              MEM_ACK = 1'b0;
  logic [31:0]       MEM_RDATA = 32'd0;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [39:0]      exp_q[$];
  logic [BUS_W-1:0] bus_q[$];
  int               cur_delay = 0;
  int               cur_exp_cyc = 0;
  bit               cur_chk = 1'b0;
  logic [31:0]      cur_rdata = 32'd0;
  logic [2:0]       ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CK_REF(CK_REF), .RST_N(RST_N), .HALT(HALT),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RD(RSP_RD), .RSP_ERR(RSP_ERR),
    .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 CK_REF = ~CK_REF;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event_seen required=no_event", name);
  endtask

  // Reference model: sizes, alignment and lanes computed arithmetically from the request.
  function automatic void ref_model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [4:0] rd,
                                    input logic [31:0] rdat, input int delay,
                                    output logic [2:0] err, output logic [39:0] rsp,
                                    output logic [BUS_W-1:0] bus);
    int size;
    longint la, mask, val, rep, mem_addr, strb;
    bit sign_ext, illegal;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    la = longint'(a);
    sign_ext = (f3 == 3'd0) || (f3 == 3'd1);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && (f3 == 3'd4 || f3 == 3'd5));
    if (illegal) err = 3'd4;
    else if (la % size != 0) err = 3'd1;
    else if (la >= (longint'(1) << ADDR_W)) err = 3'd2;
    else if (delay >= TIMEOUT) err = 3'd3;
    else err = 3'd0;
    mask = (longint'(1) << (8 * size)) - 1;
    mem_addr = (la % (longint'(1) << ADDR_W)) / 4 * 4;
    strb = w ? (((longint'(1) << size) - 1) << (la % 4)) : 0;
    rep = 0;
    if (w) for (int i = 0; i < 4 / size; i++) rep = rep | ((longint'(wd) & mask) << (8 * size * i));
    bus = {w, ADDR_W'(mem_addr), 4'(strb), 32'(rep)};
    val = (longint'(rdat) >> (8 * (la % 4))) & mask;
    if (sign_ext && val >= (mask + 1) / 2) val = val - (mask + 1);
    if (err == 3'd0 && !w) rsp = {32'(val), rd, err};
    else rsp = {32'd0, 5'd0, err};
  endfunction

  // Bus responder + bus-side scoreboard
  initial begin : bus_side
    int req_cyc;
    bit prev_req;
    logic [BUS_W-1:0] cur_bus;
    req_cyc = 0;
    prev_req = 1'b0;
    cur_bus = '0;
    forever begin
      @(negedge CK_REF);
      if (!RST_N) begin
        req_cyc = 0;
        prev_req = 1'b0;
        MEM_ACK = 1'b0;
        continue;
      end
      if (MEM_REQ) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) fail("bus_unexpected_req");
          else cur_bus = bus_q.pop_front();
        end
        check("bus_fields", {MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA}, cur_bus);
        MEM_ACK = (req_cyc == cur_delay);
        MEM_RDATA = MEM_ACK ? cur_rdata : $urandom;
        req_cyc++;
      end else begin
        if (prev_req && cur_chk) check("bus_req_cycles", req_cyc, cur_exp_cyc);
        req_cyc = 0;
        MEM_ACK = ($urandom_range(0, 3) == 0);
        MEM_RDATA = $urandom;
      end
      prev_req = MEM_REQ;
    end
  end

  // Response monitor + response scoreboard
  initial begin : rsp_side
    bit prev_v, prev_halt;
    logic [39:0] cur;
    prev_v = 1'b0;
    prev_halt = 1'b0;
    cur = '0;
    forever begin
      @(negedge CK_REF);
      if (!RST_N) begin
        prev_v = 1'b0;
        continue;
      end
      if (RSP_VALID) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) fail("rsp_unexpected");
          else begin
            cur = exp_q.pop_front();
            check("rsp_fields", {RSP_RDATA, RSP_RD, RSP_ERR}, cur);
          end
        end else begin
          if (!prev_halt) fail("rsp_longer_than_one_cycle");
          check("rsp_held_stable", {RSP_RDATA, RSP_RD, RSP_ERR}, cur);
        end
      end else if (prev_v && prev_halt) begin
        fail("rsp_dropped_under_halt");
      end
      prev_v = RSP_VALID;
      prev_halt = HALT;
    end
  end

  // Driver tasks
  task automatic wait_accept(output bit ok);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK_REF);
      if (REQ_READY) seen = 1'b1;
      @(posedge CK_REF);
      #1;
      if (seen) break;
    end
    if (!seen) fail("accept_timeout");
    ok = seen;
  endtask

  task automatic scramble_req();
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'($urandom);
    REQ_FUNCT3 = 3'($urandom);
    REQ_ADDR = $urandom;
    REQ_WDATA = $urandom;
    REQ_RD = 5'($urandom);
  endtask

  task automatic do_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdat,
                        input int delay, input int halt_idle, input int halt_resp);
    logic [2:0] err;
    logic [39:0] rsp;
    logic [BUS_W-1:0] bus;
    bit ok, got;
    ref_model(w, f3, a, wd, rd, rdat, delay, err, rsp, bus);
    cur_delay = delay;
    cur_rdata = rdat;
    cur_exp_cyc = (delay + 1 < TIMEOUT) ? delay + 1 : TIMEOUT;
    cur_chk = 1'b1;
    if (err == 3'd0 || err == 3'd3) bus_q.push_back(bus);
    exp_q.push_back(rsp);
    REQ_WRITE = w;
    REQ_FUNCT3 = f3;
    REQ_ADDR = a;
    REQ_WDATA = wd;
    REQ_RD = rd;
    REQ_VALID = 1'b1;
    HALT = (halt_idle > 0);
    for (int i = 0; i < halt_idle; i++) begin
      @(negedge CK_REF);
      check("ready_low_under_halt", REQ_READY, 0);
      @(posedge CK_REF);
      #1;
    end
    HALT = 1'b0;
    wait_accept(ok);
    scramble_req();
    if (!ok) return;
    check("stall_after_accept", {STALL, REQ_READY}, 2'b10);
    got = 1'b0;
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      if (RSP_VALID) begin
        got = 1'b1;
        break;
      end
      @(posedge CK_REF);
      #1;
    end
    if (!got) begin
      fail("rsp_timeout");
      return;
    end
    HALT = (halt_resp > 0);
    for (int i = 0; i < halt_resp; i++) begin
      @(posedge CK_REF);
      #1;
    end
    HALT = 1'b0;
    @(posedge CK_REF);
    #1;
    check("idle_after_rsp", {RSP_VALID, STALL, REQ_READY}, 3'b001);
  endtask

  task automatic reset_mid_access();
    logic [2:0] err;
    logic [39:0] rsp;
    logic [BUS_W-1:0] bus;
    bit ok;
    ref_model(1'b0, 3'b010, 32'h20, 32'd0, 5'd9, 32'd0, NEVER, err, rsp, bus);
    cur_delay = NEVER;
    cur_chk = 1'b0;
    bus_q.push_back(bus);
    REQ_WRITE = 1'b0;
    REQ_FUNCT3 = 3'b010;
    REQ_ADDR = 32'h20;
    REQ_RD = 5'd9;
    REQ_VALID = 1'b1;
    wait_accept(ok);
    scramble_req();
    repeat (3) begin
      @(posedge CK_REF);
      #1;
    end
    check("req_before_reset", MEM_REQ, 1);
    RST_N = 1'b0;
    @(posedge CK_REF);
    #1;
    check("reset_drops_req", {MEM_REQ, RSP_VALID, STALL}, 3'b000);
    RST_N = 1'b1;
    repeat (4) begin
      @(posedge CK_REF);
      #1;
      check("no_rsp_after_reset", {RSP_VALID, MEM_REQ}, 2'b00);
    end
  endtask

  // Main stimulus
  initial begin : main
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    int d, r, hi, hr;
    RST_N = 1'b0;
    repeat (3) @(posedge CK_REF);
    #1;
    check("reset_rsp", {RSP_VALID, RSP_RDATA, RSP_RD, RSP_ERR}, 0);
    check("reset_mem", {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA}, 0);
    check("reset_ctrl", {STALL, REQ_READY}, 2'b01);
    RST_N = 1'b1;
    @(posedge CK_REF);
    #1;

    do_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 0, 0, 0);
    do_txn(1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 5'd3, $urandom, 2, 0, 0);
    do_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4, $urandom, 0, 0, 0);
    do_txn(1'b0, 3'b010, 32'h0001_0000, 32'h0, 5'd4, $urandom, 0, 0, 0);
    do_txn(1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd5, $urandom, NEVER, 0, 0);
    do_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 32'hDEAD_BEEF, 5, 0, 3);
    do_txn(1'b0, 3'b110, 32'h0000_0008, 32'h0, 5'd8, $urandom, 0, 0, 0);
    do_txn(1'b1, 3'b101, 32'h0000_0001, 32'h5555_AAAA, 5'd1, $urandom, 0, 0, 0);
    do_txn(1'b0, 3'b010, 32'h0001_0001, 32'h0, 5'd2, $urandom, 0, 0, 0);
    do_txn(1'b0, 3'b001, 32'h0000_3FFE, 32'h0, 5'd10, 32'h8001_1234, TIMEOUT - 1, 0, 0);
    do_txn(1'b0, 3'b000, 32'h0000_0011, 32'h0, 5'd11, $urandom, TIMEOUT, 0, 0);
    do_txn(1'b1, 3'b000, 32'h0000_0201, 32'hCAFE_F00D, 5'd12, $urandom, 1, 2, 1);
    reset_mid_access();

    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = w ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(16, 31));
      r = int'($urandom_range(0, 19));
      if (r < 14) d = int'($urandom_range(0, 4));
      else if (r == 14) d = TIMEOUT - 2;
      else if (r == 15) d = TIMEOUT - 1;
      else if (r == 16) d = TIMEOUT;
      else if (r == 17) d = NEVER;
      else d = int'($urandom_range(5, 10));
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      hr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(w, f3, a, $urandom, 5'($urandom), $urandom, d, hi, hr);
    end

    repeat (3) @(posedge CK_REF);
    #1;
    check("rsp_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
